alu16_seq: RTL and testbench

//  Multi-cycle 16-bit arithmetic sequencer for the Z80 core: ADD HL,rr / ADC HL,rr / SBC HL,rr.

---
 rtl/alu16_seq.sv | 134 +++++++++++++
 tb/tb_alu16_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_seq.sv
// 16-bit ADD/ADC/SBC/SUB sequencer driving a shared combinational alu8 in two
// byte passes (low byte, then high byte with chained carry) and composing Z80 flags.
`ifndef ALU_FUNC_ADD
`define ALU_FUNC_ADD 4'd0
`define ALU_FUNC_ADC 4'd1
`define ALU_FUNC_SUB 4'd2
`define ALU_FUNC_SBC 4'd3
`endif

module alu16_seq #(
    parameter int SUB_C_BORROW = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    output logic [3:0]  alu_func,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_out,
    input  logic [7:0]  alu_f
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_ADC16 = 2'b01;
    localparam logic [1:0] OP_SBC16 = 2'b10;

    logic [1:0]  state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  f_q;
    logic [1:0]  op_q;
    logic [7:0]  lo_res;
    logic        lo_c;
    logic        lo_z;
    logic        is_sub;
    logic        c_out;
    logic [7:0]  f_next;

    assign is_sub = op_q[1];
    assign busy   = (state == LO) || (state == HI);
    assign done   = (state == DONE);

    always_comb begin
        alu_x    = '0;
        alu_y    = '0;
        alu_func = `ALU_FUNC_ADD;
        alu_f_in = '0;
        case (state)
            LO: begin
                alu_x    = a_q[7:0];
                alu_y    = b_q[7:0];
                alu_f_in = f_q;
                case (op_q)
                    OP_ADD16: alu_func = `ALU_FUNC_ADD;
                    OP_ADC16: alu_func = `ALU_FUNC_ADC;
                    OP_SBC16: alu_func = `ALU_FUNC_SBC;
                    default:  alu_func = `ALU_FUNC_SUB;
                endcase
            end
            HI: begin
                alu_x    = a_q[15:8];
                alu_y    = b_q[15:8];
                alu_func = is_sub ? `ALU_FUNC_SBC : `ALU_FUNC_ADC;
                // alu8 reports subtract carry as no-borrow; SBC consumes it as borrow
                alu_f_in = {f_q[7:1], is_sub ? ~lo_c : lo_c};
            end
            default: ;
        endcase
    end

    always_comb begin
        c_out = (is_sub && (SUB_C_BORROW != 0)) ? ~alu_f[0] : alu_f[0];
        if (op_q == OP_ADD16)
            f_next = {f_q[7], f_q[6], f_q[5], alu_f[4], f_q[3], f_q[2], 1'b0, alu_f[0]};
        else
            f_next = {alu_f[7], lo_z & alu_f[6], f_q[5], alu_f[4], f_q[3],
                      alu_f[2], alu_f[1], c_out};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            op_q   <= '0;
            lo_res <= '0;
            lo_c   <= 1'b0;
            lo_z   <= 1'b0;
            result <= '0;
            f_out  <= '0;
        end else begin
            case (state)
                LO: begin
                    lo_res <= alu_out;
                    lo_c   <= alu_f[0];
                    lo_z   <= alu_f[6];
                    state  <= HI;
                end
                HI: begin
                    result <= {alu_out, lo_res};
                    f_out  <= f_next;
                    state  <= DONE;
                end
                default: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        f_q   <= f_in;
                        op_q  <= op;
                        state <= LO;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural alu8 in the loop, 16-bit reference model,
// result/flag scoreboard popped on each done pulse.
`timescale 1ns/1ps
`ifndef ALU_FUNC_ADD
`define ALU_FUNC_ADD 4'd0
`define ALU_FUNC_ADC 4'd1
`define ALU_FUNC_SUB 4'd2
`define ALU_FUNC_SBC 4'd3
`endif

module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [3:0]  alu_func;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_out;
    logic [7:0]  alu_f;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] sb[$];
    logic [7:0]  lo_x_seen;
    logic [3:0]  lo_func_seen;
    logic [7:0]  hi_fin_seen;

    always #5 clk = ~clk;

    alu16_seq #(.SUB_C_BORROW(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
        .alu_x(alu_x), .alu_y(alu_y), .alu_func(alu_func), .alu_f_in(alu_f_in),
        .alu_out(alu_out), .alu_f(alu_f)
    );

    // alu8: subtract C is no-borrow (raw carry), H is half-borrow, SBC takes C as borrow
    logic [8:0] s9;
    logic [4:0] h5;
    logic       sub8;
    logic       v8;
    always_comb begin
        s9   = '0;
        h5   = '0;
        sub8 = 1'b0;
        case (alu_func)
            `ALU_FUNC_ADC: begin
                s9 = {1'b0, alu_x} + {1'b0, alu_y} + {8'd0, alu_f_in[0]};
                h5 = {1'b0, alu_x[3:0]} + {1'b0, alu_y[3:0]} + {4'd0, alu_f_in[0]};
            end
            `ALU_FUNC_SUB: begin
                sub8 = 1'b1;
                s9 = {1'b0, alu_x} + {1'b0, ~alu_y} + 9'd1;
                h5 = {1'b0, alu_x[3:0]} - {1'b0, alu_y[3:0]};
            end
            `ALU_FUNC_SBC: begin
                sub8 = 1'b1;
                s9 = {1'b0, alu_x} + {1'b0, ~alu_y} + {8'd0, ~alu_f_in[0]};
                h5 = {1'b0, alu_x[3:0]} - {1'b0, alu_y[3:0]} - {4'd0, alu_f_in[0]};
            end
            default: begin
                s9 = {1'b0, alu_x} + {1'b0, alu_y};
                h5 = {1'b0, alu_x[3:0]} + {1'b0, alu_y[3:0]};
            end
        endcase
        alu_out = s9[7:0];
        v8 = sub8 ? ((alu_x[7] != alu_y[7]) && (s9[7] != alu_x[7]))
                  : ((alu_x[7] == alu_y[7]) && (s9[7] != alu_x[7]));
        alu_f = {s9[7], s9[7:0] == 8'd0, s9[5], h5[4], s9[3], v8, sub8, s9[8]};
    end

    function automatic logic [23:0] model16(input logic [1:0] o, input logic [15:0] x,
                                            input logic [15:0] y, input logic [7:0] f);
        logic [16:0] r;
        logic [12:0] h;
        logic        cin;
        logic        s, z, hf, v, n, c;
        cin = (o == 2'b01 || o == 2'b10) ? f[0] : 1'b0;
        if (!o[1]) begin
            r = {1'b0, x} + {1'b0, y} + {16'd0, cin};
            h = {1'b0, x[11:0]} + {1'b0, y[11:0]} + {12'd0, cin};
            v = (x[15] == y[15]) && (r[15] != x[15]);
            n = 1'b0;
            c = r[16];
        end else begin
            r = {1'b0, x} - {1'b0, y} - {16'd0, cin};
            h = {1'b0, x[11:0]} - {1'b0, y[11:0]} - {12'd0, cin};
            v = (x[15] != y[15]) && (r[15] != x[15]);
            n = 1'b1;
            c = r[16];
        end
        hf = h[12];
        s  = r[15];
        z  = (r[15:0] == 16'd0);
        if (o == 2'b00) begin
            s = f[7];
            z = f[6];
            v = f[2];
        end
        return {r[15:0], s, z, f[5], hf, f[3], v, n, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] f, input logic [23:0] exp);
        op = o; a = x; b = y; f_in = f; start = 1'b1;
        sb.push_back(exp);
    endtask

    // Waits for done; first negedge after the drive counts as 1, so done must be seen at 3
    task automatic wait_done(input string tag, input bit glitch);
        int lat;
        logic [23:0] exp;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = glitch && (c < 3);
            if (glitch && c < 3) begin
                a = 16'($urandom);
                b = 16'($urandom);
                f_in = 8'($urandom);
                op = 2'($urandom);
            end
            if (c == 1) begin
                lo_x_seen = alu_x;
                lo_func_seen = alu_func;
                check({tag, " busy_lo"}, 32'(busy), 32'd1);
            end
            if (c == 2) hi_fin_seen = alu_f_in;
            if (done) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, 3);
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " result"}, 32'(result), 32'(exp[23:8]));
            check({tag, " f_out"}, 32'(f_out), 32'(exp[7:0]));
        end
    endtask

    initial begin
        bit saw_done;
        logic [1:0]  ro;
        logic [15:0] rx, ry;
        logic [7:0]  rf;

        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; f_in = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst f_out", 32'(f_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle alu", {alu_x, alu_y, alu_func, alu_f_in, 4'd0},
              {8'd0, 8'd0, `ALU_FUNC_ADD, 8'd0, 4'd0});

        drive(2'b00, 16'h1234, 16'h0FCC, 8'hC5, {16'h2200, 8'hD4});
        wait_done("add16", 1'b0);
        check("add16 lo_x", 32'(lo_x_seen), 32'h34);
        check("add16 lo_func", 32'(lo_func_seen), 32'(`ALU_FUNC_ADD));
        @(negedge clk);
        check("add16 done_pulse", 32'(done), 32'd0);
        check("add16 held", 32'({result, f_out}), 32'h2200D4);

        drive(2'b01, 16'hFFFF, 16'h0000, 8'h01, {16'h0000, 8'h51});
        wait_done("adc16", 1'b0);
        @(negedge clk);

        drive(2'b10, 16'h8000, 16'h0001, 8'h00, {16'h7FFF, 8'h16});
        wait_done("sbc16", 1'b0);
        check("sbc16 hi_fin_c", 32'(hi_fin_seen[0]), 32'd1);
        check("sbc16 lo_func", 32'(lo_func_seen), 32'(`ALU_FUNC_SBC));
        @(negedge clk);

        drive(2'b10, 16'h0000, 16'h0000, 8'h01, {16'hFFFF, 8'h93});
        wait_done("sbc16_zero", 1'b0);
        @(negedge clk);

        drive(2'b11, 16'h0100, 16'h0100, 8'h29, model16(2'b11, 16'h0100, 16'h0100, 8'h29));
        wait_done("sub16", 1'b0);
        check("sub16 lo_func", 32'(lo_func_seen), 32'(`ALU_FUNC_SUB));
        @(negedge clk);

        drive(2'b00, 16'h1234, 16'h0FCC, 8'hC5, {16'h2200, 8'hD4});
        wait_done("ignore", 1'b1);
        drive(2'b01, 16'hFFFF, 16'h0000, 8'h01, {16'h0000, 8'h51});
        wait_done("b2b", 1'b0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            rx = 16'($urandom);
            ry = (i == 3) ? rx : 16'($urandom);
            rf = 8'($urandom);
            drive(ro, rx, ry, rf, model16(ro, rx, ry, rf));
            wait_done($sformatf("rand%0d op%0d", i, ro), 1'b0);
        end
        @(negedge clk);

        drive(2'b01, 16'h7FFF, 16'h0001, 8'h00, model16(2'b01, 16'h7FFF, 16'h0001, 8'h00));
        sb.delete();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort f_out", 32'(f_out), 32'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", 32'(saw_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
